// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge.
// State encoding, timeout defaults and the timeout read pattern.
package dmem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RWAIT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int          TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_wait_timer.sv
// Clearable saturating 8-bit wait counter for the memory bridge.
// o_expired rises once the count has reached i_limit.
module bus_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic [7:0] i_limit,
    output logic       o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_inc && r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count >= i_limit);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's single-cycle load/store port onto a
// valid/ready memory bus, stalling the core while it waits.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_rdata;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_err_mis;
    logic        r_err_to;

    logic w_aligned;
    logic w_start;
    logic w_misalign;
    logic w_inc;
    logic w_expired;

    assign w_aligned  = (cpu_addr[1:0] == 2'b00);
    assign w_start    = (r_state == S_IDLE) && cpu_req && w_aligned;
    assign w_misalign = (r_state == S_IDLE) && cpu_req && !w_aligned;
    assign w_inc      = ((r_state == S_REQ) && !bus_ready) ||
                        ((r_state == S_RWAIT) && !bus_rvalid);

    bus_wait_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_start),
        .i_inc     (w_inc),
        .i_limit   (LIMIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rdata     <= 32'd0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_err_mis   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_bus_we    <= cpu_we;
                        r_bus_addr  <= cpu_addr;
                        r_bus_wdata <= cpu_wdata;
                        r_state     <= S_REQ;
                    end else if (w_misalign) begin
                        r_rdata   <= 32'd0;
                        r_err_mis <= 1'b1;
                    end
                end
                S_REQ: begin
                    // completion takes priority over an expiring timer
                    if (bus_ready) begin
                        r_state <= r_bus_we ? S_DONE : S_RWAIT;
                    end else if (w_expired) begin
                        r_err_to <= 1'b1;
                        if (!r_bus_we) begin
                            r_rdata <= TIMEOUT_RDATA;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_RWAIT: begin
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                        r_state <= S_DONE;
                    end else if (w_expired) begin
                        r_err_to <= 1'b1;
                        r_rdata  <= TIMEOUT_RDATA;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // a misaligned access commits in its own cycle, so zero it here
    assign cpu_rdata    = w_misalign ? 32'd0 : r_rdata;
    assign stall        = w_start || (r_state == S_REQ) ||
                          (r_state == S_RWAIT);
    assign bus_valid    = (r_state == S_REQ);
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign err_misalign = r_err_mis;
    assign err_timeout  = r_err_to;

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16; the number of bus-wait cycles allowed before the transaction is aborted; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  the CPU core has a load or store in the current cycle; held stable while stall=1.
REQ-005 cpu_we  input  1  1=store, 0=load; held stable while stall=1.
REQ-006 cpu_addr  input  32  byte address from the ALU result; held stable while stall=1.
REQ-007 cpu_wdata  input  32  store data; held stable while stall=1.
REQ-008 cpu_rdata  output  32  load data returned to the core.
REQ-009 stall  output  1  freezes the PC and register-file write of the core.
REQ-010 bus_valid  output  1  request valid on the external memory bus.
REQ-011 bus_ready  input  1  the bus accepts the request in the current cycle.
REQ-012 bus_we, bus_addr[31:0], bus_wdata[31:0]  output  registered request fields.
REQ-013 bus_rvalid  input  1; bus_rdata  input  32  read response.
REQ-014 err_misalign, err_timeout  output  1 each  sticky error flags.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, RWAIT and DONE.
REQ-016 IDLE, on cpu_req=1 with cpu_addr[1:0]=0: the block SHALL latch we, addr and wdata into the bus_* registers and go to REQ.
REQ-017 IDLE, on cpu_req=1 with cpu_addr[1:0]!=0: the block SHALL issue no bus request, keep stall=0, return cpu_rdata=0 and set err_misalign; the state SHALL remain IDLE.
REQ-018 stall SHALL be combinational: 1 when (IDLE and cpu_req and aligned), 1 in REQ, 1 in RWAIT, and 0 otherwise.
REQ-019 bus_valid SHALL be 1 only in REQ, and bus_* fields SHALL stay constant while bus_valid=1.
REQ-020 REQ, on bus_ready=1: the block SHALL go to DONE when bus_we=1, and to RWAIT when bus_we=0.
REQ-021 RWAIT, on bus_rvalid=1: the block SHALL register bus_rdata into cpu_rdata and go to DONE.
REQ-022 bus_rvalid SHALL be ignored in every state except RWAIT.
REQ-023 In DONE, stall SHALL be 0 and cpu_rdata SHALL hold its value, so the core commits at this clock edge.
REQ-024 DONE SHALL go to IDLE unconditionally, so back-to-back memory instructions are separated by one IDLE cycle.
REQ-025 An 8-bit wait counter SHALL clear when entering REQ and increment each cycle spent in REQ or RWAIT without completion.
REQ-026 When the wait counter reaches TIMEOUT-1 without completion, the block SHALL go to DONE, set cpu_rdata=32'hDEADBEEF for loads, set err_timeout and drop bus_valid.
REQ-027 When completion and timeout occur in the same cycle, completion SHALL win and err_timeout SHALL stay unchanged.
REQ-028 For a store, latency SHALL be 1 cycle in REQ plus the bus wait, plus 1 DONE cycle; the minimum stall length is 1 cycle after the request cycle.
REQ-029 For a load, the minimum total latency SHALL be IDLE to REQ to RWAIT to DONE, i.e. 2 stall cycles.
REQ-030 err_misalign and err_timeout SHALL be cleared only by reset.

Reset
REQ-031 reset SHALL immediately force the state to IDLE, including in the middle of a transaction.
REQ-032 During and after reset, bus_valid SHALL be 0, cpu_rdata SHALL be 0, and bus_we, bus_addr and bus_wdata SHALL be 0.
REQ-033 During and after reset, both error flags SHALL be 0 and the wait counter SHALL be 0.
REQ-034 An abandoned bus transaction SHALL NOT be resumed after reset.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=0, REQ=1, RWAIT=2, DONE=3), TIMEOUT_DEFAULT=16 and TIMEOUT_RDATA=32'hDEADBEEF.
REQ-036 One sub-module, bus_wait_timer, SHALL implement the clearable saturating wait counter and its expired flag.
REQ-037 The FSM and data registers SHALL stay in the top module.

Verification
REQ-038 Store to 0x54 with data 7, bus_ready high on the 1st REQ cycle -> bus_addr=0x54, bus_wdata=7, bus_we=1, stall high for exactly 1 cycle, then DONE.
REQ-039 Load from 0x50, bus_ready after 3 cycles, rvalid 2 cycles later with 0x12345678 -> cpu_rdata=0x12345678 in DONE, and stall high for the whole wait.
REQ-040 Load from 0x51 -> no bus_valid, stall=0, err_misalign=1, cpu_rdata=0.
REQ-041 Load with bus_ready never asserted and TIMEOUT=16 -> bus_valid drops after 16 cycles, cpu_rdata=0xDEADBEEF, err_timeout=1.
REQ-042 reset asserted in RWAIT -> bus_valid=0 and state IDLE immediately; a later bus_rvalid is ignored and cpu_rdata stays 0.
REQ-043 Back-to-back store then load -> each instruction is served exactly once, with one IDLE cycle between them, and bus_rvalid outside RWAIT has no effect.
